// File: rtl/multdiv_pkg.sv
// Shared types for the iterative multiply/divide unit: FSM states, operation
// encoding and the iteration-counter width.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MUL_LO = 2'd0,
    MUL_HI = 2'd1,
    DIV_Q  = 2'd2,
    DIV_R  = 2'd3
  } op_e;

  // The counter must hold 0..width so that a full run of width steps is representable.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multdiv_core.sv
// Unsigned iterative datapath: one shift-add multiply bit or one restoring
// divide bit per step, sharing a single adder/subtractor.
module multdiv_core
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a_mag,
  input  logic [WIDTH-1:0]     b_mag,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // acc holds {product hi, product lo/multiplier} or {remainder, quotient/dividend}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH+1:0]   add_x, add_y, add_sum;

  // Two guard bits: bit WIDTH catches the multiply carry, bit WIDTH+1 the divide borrow.
  always_comb begin
    add_x = '0;
    add_y = '0;
    if (is_div) begin
      add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]};
      add_y = ~{2'b00, opb_q};
    end else begin
      add_x = {2'b00, acc_q[2*WIDTH-1:WIDTH]};
      add_y = {2'b00, opb_q};
    end
    add_sum = add_x + add_y + {{(WIDTH+1){1'b0}}, is_div};
  end

  always_comb begin
    acc_d = acc_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = {{WIDTH{1'b0}}, a_mag};
      opb_d = b_mag;
      cnt_d = '0;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (is_div) begin
        if (add_sum[WIDTH+1]) begin
          acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
      end else begin
        if (acc_q[0]) begin
          acc_d = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == LAST_CNT);

endmodule

// File: rtl/multdiv_param.sv
// Iterative multiply/divide unit: control FSM, operand sign handling and
// registered result/exception/ready outputs around multdiv_core.
module multdiv_param
  import multdiv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_HIGH,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   neg_q, neg_d;
  logic   rneg_q, rneg_d;
  logic   div0_q, div0_d;
  logic   ovf_q, ovf_d;

  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic               sign_a, sign_b, start, complete;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               core_load, core_step, core_is_div, core_last;
  logic [2*WIDTH-1:0] core_acc;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH:0]     prod_top;
  logic [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

  always_comb begin
    sign_a = (SIGNED != 0) && data_operandA[WIDTH-1];
    sign_b = (SIGNED != 0) && data_operandB[WIDTH-1];
    a_mag  = sign_a ? -data_operandA : data_operandA;
    b_mag  = sign_b ? -data_operandB : data_operandB;
    start  = ctrl_MULT | ctrl_DIV;
  end

  // Signs are reapplied to the unsigned core result once iteration has finished.
  always_comb begin
    prod_s   = neg_q ? -core_acc : core_acc;
    prod_top = prod_s[2*WIDTH-1:WIDTH-1];
    quot_s   = neg_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
    rem_s    = rneg_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
    fin_result = '0;
    fin_exc    = 1'b0;
    case (op_q)
      MUL_LO: begin
        fin_result = prod_s[WIDTH-1:0];
        if (SIGNED != 0) begin
          fin_exc = !((&prod_top) || !(|prod_top));
        end else begin
          fin_exc = |prod_s[2*WIDTH-1:WIDTH];
        end
      end
      MUL_HI: begin
        fin_result = prod_s[2*WIDTH-1:WIDTH];
        fin_exc    = 1'b0;
      end
      DIV_Q: begin
        fin_result = div0_q ? '0 : quot_s;
        fin_exc    = div0_q | ovf_q;
      end
      default: begin
        fin_result = div0_q ? '0 : rem_s;
        fin_exc    = div0_q | ovf_q;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    core_load   = 1'b0;
    core_step   = 1'b0;
    core_is_div = (state_q == DIV);
    complete    = 1'b0;

    case (state_q)
      MUL: begin
        core_step = 1'b1;
        if (core_last) state_d = DONE;
      end
      DIV: begin
        // A zero divisor finishes one edge after the start without iterating.
        if (div0_q) begin
          complete = !start;
          state_d  = IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) state_d = DONE;
        end
      end
      DONE: begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      rdy_d    = 1'b1;
      result_d = fin_result;
      exc_d    = fin_exc;
    end

    // A new start always wins over the in-flight operation; multiply wins over divide.
    if (start) begin
      core_load = 1'b1;
      neg_d     = sign_a ^ sign_b;
      rneg_d    = sign_a;
      if (ctrl_MULT) begin
        state_d = MUL;
        op_d    = ctrl_HIGH ? MUL_HI : MUL_LO;
        div0_d  = 1'b0;
        ovf_d   = 1'b0;
      end else begin
        state_d = DIV;
        op_d    = ctrl_HIGH ? DIV_R : DIV_Q;
        div0_d  = (data_operandB == '0);
        ovf_d   = (SIGNED != 0) && (data_operandA == MOST_NEG) &&
                  (data_operandB == {WIDTH{1'b1}});
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MUL_LO;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  multdiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (core_is_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (core_acc),
    .last   (core_last)
  );

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_param.sv
// Directed bench for multdiv_param: 32-bit signed, 8-bit signed and 32-bit
// unsigned instances share stimulus; each test observes one selected instance.
module tb_multdiv_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div  = 1'b0;
  logic        ctrl_high = 1'b0;

  logic [31:0] res_s32, res_u32;
  logic [7:0]  res_s8;
  logic        exc_s32, exc_s8, exc_u32;
  logic        rdy_s32, rdy_s8, rdy_u32;
  logic        busy_s32, busy_s8, busy_u32;
  logic [1:0]  st_s32, st_s8, st_u32;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic [31:0] obs_result;
  logic        obs_exc, obs_rdy, obs_busy;
  logic [1:0]  obs_state;

  always #5 clock = ~clock;

  multdiv_param #(.WIDTH(32), .SIGNED(1)) dut_s32 (
    .clock(clock), .reset(reset), .data_operandA(a), .data_operandB(b),
    .ctrl_MULT(ctrl_mult), .ctrl_DIV(ctrl_div), .ctrl_HIGH(ctrl_high),
    .data_result(res_s32), .data_exception(exc_s32), .data_resultRDY(rdy_s32),
    .busy(busy_s32), .dbg_state(st_s32)
  );

  multdiv_param #(.WIDTH(8), .SIGNED(1)) dut_s8 (
    .clock(clock), .reset(reset), .data_operandA(a[7:0]), .data_operandB(b[7:0]),
    .ctrl_MULT(ctrl_mult), .ctrl_DIV(ctrl_div), .ctrl_HIGH(ctrl_high),
    .data_result(res_s8), .data_exception(exc_s8), .data_resultRDY(rdy_s8),
    .busy(busy_s8), .dbg_state(st_s8)
  );

  multdiv_param #(.WIDTH(32), .SIGNED(0)) dut_u32 (
    .clock(clock), .reset(reset), .data_operandA(a), .data_operandB(b),
    .ctrl_MULT(ctrl_mult), .ctrl_DIV(ctrl_div), .ctrl_HIGH(ctrl_high),
    .data_result(res_u32), .data_exception(exc_u32), .data_resultRDY(rdy_u32),
    .busy(busy_u32), .dbg_state(st_u32)
  );

  always_comb begin
    obs_result = res_s32;
    obs_exc    = exc_s32;
    obs_rdy    = rdy_s32;
    obs_busy   = busy_s32;
    obs_state  = st_s32;
    if (sel == 1) begin
      obs_result = {24'h0, res_s8};
      obs_exc    = exc_s8;
      obs_rdy    = rdy_s8;
      obs_busy   = busy_s8;
      obs_state  = st_s8;
    end else if (sel == 2) begin
      obs_result = res_u32;
      obs_exc    = exc_u32;
      obs_rdy    = rdy_u32;
      obs_busy   = busy_u32;
      obs_state  = st_u32;
    end
  end

  // Start is sampled on the posedge that follows; that posedge is edge 0.
  task automatic start_op(input logic mul, input logic div, input logic high,
                          input logic [31:0] opa, input logic [31:0] opb);
    @(negedge clock);
    a = opa; b = opb; ctrl_mult = mul; ctrl_div = div; ctrl_high = high;
    @(posedge clock);
    #1;
    ctrl_mult = 1'b0; ctrl_div = 1'b0;
  endtask

  // Sample n is taken in the cycle after edge n.
  task automatic collect(input int cycles, output int n_rdy, output int first_rdy,
                         output int n_busy, output logic [31:0] res, output logic exc);
    n_rdy = 0; first_rdy = -1; n_busy = 0; res = '0; exc = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clock);
      if (obs_busy) n_busy++;
      if (obs_rdy) begin
        n_rdy++;
        if (first_rdy < 0) begin
          first_rdy = n; res = obs_result; exc = obs_exc;
        end
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if (res_s32 !== 32'h0 || exc_s32 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: result %h exc %b, want 0 0", res_s32, exc_s32);
    end
    checks++;
    if (rdy_s32 !== 1'b0 || busy_s32 !== 1'b0 || st_s32 !== 2'd0) begin
      errors++; $display("FAIL reset_ctrl: rdy %b busy %b state %0d, want 0 0 0", rdy_s32, busy_s32, st_s32);
    end
    checks++;
    if (res_s8 !== 8'h0 || busy_s8 !== 1'b0 || res_u32 !== 32'h0 || busy_u32 !== 1'b0) begin
      errors++; $display("FAIL reset_other: s8 %h/%b u32 %h/%b, want 0/0", res_s8, busy_s8, res_u32, busy_u32);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult_basic();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 0;
    start_op(1'b1, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFA);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (nr !== 1 || fr !== 33) begin
      errors++; $display("FAIL mul_rdy_timing: %0d pulses first at %0d, want 1 at 33", nr, fr);
    end
    checks++;
    if (nb !== 33) begin
      errors++; $display("FAIL mul_busy_len: %0d, want 33", nb);
    end
    checks++;
    if (r !== 32'hFFFF_FFD6 || e !== 1'b0) begin
      errors++; $display("FAIL mul_7x-6: result %h exc %b, want ffffffd6 0", r, e);
    end
  endtask

  task automatic test_mult_overflow();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 0;
    start_op(1'b1, 1'b0, 1'b1, 32'h4000_0000, 32'd4);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h1 || e !== 1'b0 || nr !== 1) begin
      errors++; $display("FAIL mul_high: result %h exc %b rdy %0d, want 1 0 1", r, e, nr);
    end
    start_op(1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'd4);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h0 || e !== 1'b1 || nr !== 1) begin
      errors++; $display("FAIL mul_low_ovf: result %h exc %b rdy %0d, want 0 1 1", r, e, nr);
    end
  endtask

  task automatic test_div_signed();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 0;
    start_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'hFFFF_FFFD || e !== 1'b0 || fr !== 33) begin
      errors++; $display("FAIL div_quot: result %h exc %b rdy_at %0d, want fffffffd 0 33", r, e, fr);
    end
    start_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'hFFFF_FFFF || e !== 1'b0) begin
      errors++; $display("FAIL div_rem: result %h exc %b, want ffffffff 0", r, e);
    end
  endtask

  task automatic test_div_zero();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 0;
    start_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    collect(10, nr, fr, nb, r, e);
    checks++;
    if (nr !== 1 || fr !== 1 || nb !== 1) begin
      errors++; $display("FAIL div0_timing: rdy %0d at %0d busy %0d, want 1 at 1 busy 1", nr, fr, nb);
    end
    checks++;
    if (r !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL div0_value: result %h exc %b, want 0 1", r, e);
    end
  endtask

  task automatic test_div_overflow();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 0;
    start_op(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h8000_0000 || e !== 1'b1 || fr !== 33) begin
      errors++; $display("FAIL div_ovf: result %h exc %b rdy_at %0d, want 80000000 1 33", r, e, fr);
    end
  endtask

  task automatic test_both_starts();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 0;
    start_op(1'b1, 1'b1, 1'b0, 32'd3, 32'd3);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'd9 || nr !== 1 || fr !== 33) begin
      errors++; $display("FAIL both_starts: result %0d rdy %0d at %0d, want 9 1 at 33", r, nr, fr);
    end
  endtask

  task automatic test_abort();
    int nr = 0; int fr = -1; logic [31:0] r = '0;
    sel = 0;
    start_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (obs_rdy) begin
        nr++;
        if (fr < 0) begin fr = n; r = obs_result; end
      end
      if (n == 9) begin a = 32'd3; b = 32'd3; ctrl_high = 1'b0; ctrl_mult = 1'b1; end
      if (n == 10) ctrl_mult = 1'b0;
    end
    checks++;
    if (nr !== 1 || fr !== 43 || r !== 32'd9) begin
      errors++; $display("FAIL abort_restart: rdy %0d at %0d result %0d, want 1 at 43 result 9", nr, fr, r);
    end
  endtask

  task automatic test_reset_mid();
    int nr = 0;
    sel = 0;
    start_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (obs_rdy) nr++;
      if (n == 5) begin
        checks++;
        if (obs_busy !== 1'b0 || obs_result !== 32'h0 || obs_exc !== 1'b0 || obs_state !== 2'd0) begin
          errors++;
          $display("FAIL reset_mid_outputs: busy %b result %h exc %b state %0d, want 0 0 0 0",
                   obs_busy, obs_result, obs_exc, obs_state);
        end
        reset = 1'b0;
      end
      if (n == 4) reset = 1'b1;
    end
    checks++;
    if (nr !== 0) begin
      errors++; $display("FAIL reset_mid_rdy: %0d pulses, want 0", nr);
    end
  endtask

  task automatic test_start_in_done();
    int nr = 0;
    int at0 = -1; int at1 = -1;
    logic [31:0] r0 = '0; logic [31:0] r1 = '0;
    logic [1:0] st32 = '0;
    sel = 0;
    start_op(1'b1, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFA);
    for (int n = 0; n < 75; n++) begin
      @(negedge clock);
      if (obs_rdy) begin
        if (nr == 0) begin at0 = n; r0 = obs_result; end
        if (nr == 1) begin at1 = n; r1 = obs_result; end
        nr++;
      end
      if (n == 32) begin
        st32 = obs_state;
        a = 32'hFFFF_FFF9; b = 32'd2; ctrl_high = 1'b0; ctrl_div = 1'b1;
      end
      if (n == 33) ctrl_div = 1'b0;
    end
    checks++;
    if (st32 !== 2'd3) begin
      errors++; $display("FAIL done_state: state %0d after edge 32, want 3", st32);
    end
    checks++;
    if (nr !== 2 || at0 !== 33 || r0 !== 32'hFFFF_FFD6) begin
      errors++; $display("FAIL done_restart_first: %0d pulses first at %0d result %h, want 2 at 33 ffffffd6", nr, at0, r0);
    end
    checks++;
    if (at1 !== 66 || r1 !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL done_restart_second: at %0d result %h, want 66 fffffffd", at1, r1);
    end
  endtask

  task automatic test_width8();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 1;
    start_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd3);
    collect(12, nr, fr, nb, r, e);
    checks++;
    if (nr !== 1 || fr !== 9 || nb !== 9 || r !== 32'd9 || e !== 1'b0) begin
      errors++; $display("FAIL w8_mul: rdy %0d at %0d busy %0d result %h exc %b, want 1 at 9 busy 9 09 0", nr, fr, nb, r, e);
    end
    start_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    collect(12, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h0000_00FD || e !== 1'b0 || fr !== 9) begin
      errors++; $display("FAIL w8_div_quot: result %h exc %b rdy_at %0d, want 000000fd 0 9", r, e, fr);
    end
    start_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    collect(12, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h0000_00FF || e !== 1'b0) begin
      errors++; $display("FAIL w8_div_rem: result %h exc %b, want 000000ff 0", r, e);
    end
    collect(30, nr, fr, nb, r, e);
  endtask

  task automatic test_unsigned();
    int nr, fr, nb; logic [31:0] r; logic e;
    sel = 2;
    start_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd3);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'd9 || e !== 1'b0 || fr !== 33) begin
      errors++; $display("FAIL u_mul: result %h exc %b rdy_at %0d, want 9 0 33", r, e, fr);
    end
    start_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h7FFF_FFFC || e !== 1'b0) begin
      errors++; $display("FAIL u_div_quot: result %h exc %b, want 7ffffffc 0", r, e);
    end
    start_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h1 || e !== 1'b0) begin
      errors++; $display("FAIL u_div_rem: result %h exc %b, want 1 0", r, e);
    end
    start_op(1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'd4);
    collect(40, nr, fr, nb, r, e);
    checks++;
    if (r !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL u_mul_ovf: result %h exc %b, want 0 1", r, e);
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_overflow();
    test_div_signed();
    test_div_zero();
    test_div_overflow();
    test_both_starts();
    test_abort();
    test_reset_mid();
    test_start_in_done();
    test_width8();
    test_unsigned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_param.md
MULTDIV_PARAM -- requirements
Module: multdiv_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64, even).
REQ-002 The block SHALL have parameter SIGNED, default 1, where 1 selects two's-complement operation and 0 selects unsigned operation.
REQ-003 The block SHALL have port clock, input, width 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1, synchronous active-high reset.
REQ-005 The block SHALL have ports data_operandA and data_operandB, input, width WIDTH each, the operands, sampled only on a start edge.
REQ-006 The block SHALL have port ctrl_MULT, input, width 1, a one-cycle start pulse for a multiply.
REQ-007 The block SHALL have port ctrl_DIV, input, width 1, a one-cycle start pulse for a divide.
REQ-008 The block SHALL have port ctrl_HIGH, input, width 1, sampled with a start: for multiply it selects the upper WIDTH product bits; for divide it selects the remainder.
REQ-009 The block SHALL have port data_result, output, width WIDTH, the registered result.
REQ-010 The block SHALL have port data_exception, output, width 1, the registered exception flag.
REQ-011 The block SHALL have port data_resultRDY, output, width 1, a one-cycle completion pulse.
REQ-012 The block SHALL have port busy, output, width 1, high while an operation is in progress.

Function
REQ-013 The block SHALL implement FSM states IDLE, MUL, DIV and DONE; a start moves IDLE/MUL/DIV/DONE to MUL or DIV, MUL/DIV move to DONE after WIDTH iteration cycles, and DONE moves to IDLE.
REQ-014 The multiply SHALL iterate one bit per cycle (shift-add, or radix-2 Booth when SIGNED=1) into a 2*WIDTH-bit product.
REQ-015 The divide SHALL iterate one quotient bit per cycle (restoring or non-restoring) on operand magnitudes, then apply signs: quotient negative iff operand signs differ, remainder takes the dividend's sign.
REQ-016 With start sampled on edge 0, data_resultRDY SHALL be high for exactly the cycle after edge WIDTH+1, and busy SHALL be high from edge 0 until edge WIDTH+1.
REQ-017 data_result and data_exception SHALL update on the same edge that raises data_resultRDY, and SHALL hold until the next completion or reset.
REQ-018 For a low-half multiply, data_exception SHALL be 1 when the full product does not fit in WIDTH bits (signed or unsigned per SIGNED); a high-half multiply SHALL never raise an exception.
REQ-019 A divide with data_operandB = 0 SHALL skip iteration: data_resultRDY pulses in the cycle after edge 1, data_result = 0, data_exception = 1.
REQ-020 With SIGNED=1, the divide (most negative value) / -1 SHALL return quotient = most negative value, remainder = 0, data_exception = 1, with normal latency.
REQ-021 A start while busy SHALL abort the current operation without a data_resultRDY pulse and restart with the new operands.
REQ-022 If ctrl_MULT and ctrl_DIV are both high on one edge, the multiply SHALL start and ctrl_DIV SHALL be ignored.
REQ-023 A start in DONE SHALL be accepted; the completion pulse for the old operation still occurs that cycle.

Reset
REQ-024 Reset SHALL force state IDLE, data_result = 0, data_exception = 0, data_resultRDY = 0 and busy = 0 on the next edge.
REQ-025 Reset SHALL take priority over a simultaneous start, and a reset mid-operation SHALL discard the operation with no completion pulse.

Structure
REQ-026 The FSM state enum, the op encoding (MUL_LO, MUL_HI, DIV_Q, DIV_R) and the iteration-count width $clog2(WIDTH+1) SHALL live in shared package multdiv_pkg.
REQ-027 The iterative datapath (shared adder/subtractor, product/remainder shift registers, iteration counter) SHALL be one sub-module named multdiv_core, with the FSM, sign handling and output registers in multdiv_param.

Verification
REQ-028 The bench SHALL cover, at WIDTH=32 and SIGNED=1:
- MULT 7 x -6, HIGH=0 -> result -42, exc 0, RDY only in the cycle after edge 33.
- MULT 0x40000000 x 4: HIGH=1 -> result 1, exc 0; HIGH=0 -> result 0, exc 1.
- DIV -7 / 2: HIGH=0 -> -3; HIGH=1 -> -1; exc 0.
- DIV 5 / 0 -> RDY in the cycle after edge 1, result 0, exc 1.
- DIV 0x80000000 / -1 -> result 0x80000000, exc 1.
- Abort and reset:
  - DIV 100/7 restarted at edge 10 with MULT 3 x 3 -> single RDY at edge 10+33, result 9.
  - Reset at edge 5 -> no RDY and all outputs 0.
REQ-029 The bench SHALL also run the 3 x 3 and -7 / 2 cases at WIDTH=8 (latency 9) and at SIGNED=0.
